// File: rtl/project_dispatcher_if.sv
// project_dispatcher_if: bundles the operand stream, the job link to `project`
// and the result stream of project_dispatcher.
//   in_valid/in_data/in_ready       operand stream into the dispatcher FIFO
//   start/valor/resultado/done      job launch and completion with `project`
//   out_valid/out_data/out_err/out_ready  result stream to the consumer
//   busy/count                      status (FSM not idle, FIFO occupancy)
// slave is the dispatcher side; master is the environment side.
interface project_dispatcher_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            start;
    logic [7:0]      valor;
    logic [7:0]      resultado;
    logic            done;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_err;
    logic            out_ready;
    logic            busy;
    logic [CntW-1:0] count;

    modport master (
        output in_valid, in_data, resultado, done, out_ready,
        input  in_ready, start, valor, out_valid, out_data, out_err, busy, count
    );

    modport slave (
        input  in_valid, in_data, resultado, done, out_ready,
        output in_ready, start, valor, out_valid, out_data, out_err, busy, count
    );
endinterface

// File: rtl/project_dispatcher.sv
// project_dispatcher: buffers 8-bit operands in a FIFO and runs them through the
// `project` block one job at a time (start pulse, wait for done), returning each
// result over a valid/ready register. A watchdog turns a missing done into an
// 8'hFF result flagged with out_err.
// Ports:
//   clk0  rising-edge clock
//   rst0  asynchronous active-low reset
//   bus   project_dispatcher_if.slave (operand, job and result handshakes)
module project_dispatcher #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk0,
    input logic                 rst0,
    project_dispatcher_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StHold   = 2'd3;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop;

    logic [1:0] state_q, state_d;
    logic       start_q, start_d;
    logic [7:0] valor_q, valor_d;
    logic [7:0] wdog_q, wdog_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_err_q, out_err_d;

    assign bus.in_ready = (count_q < CntW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    // The only pop is the IDLE->LAUNCH transition.
    assign pop          = (state_q == StIdle) && (count_q != '0);

    // Storage needs no reset: occupancy is what reset clears.
    always_ff @(posedge clk0) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        valor_d     = valor_q;
        wdog_d      = wdog_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    valor_d = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                wdog_d  = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                // done wins over a watchdog expiry on the same edge.
                if (bus.done) begin
                    out_data_d  = bus.resultado;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else if (wdog_q == 8'(TIMEOUT - 1)) begin
                    out_data_d  = 8'hFF;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            StHold: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            valor_q     <= 8'd0;
            wdog_q      <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            valor_q     <= valor_d;
            wdog_q      <= wdog_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.start     = start_q;
    assign bus.valor     = valor_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.count     = count_q;
endmodule

// File: tb/tb_project_dispatcher.sv
// tb_project_dispatcher: directed bench for project_dispatcher with a small
// behavioural `project` model (squares valor, done a fixed delay after start).
module tb_project_dispatcher;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic clk0;
    logic rst0;

    project_dispatcher_if #(.DEPTH(DEPTH)) bus ();

    project_dispatcher #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // project model controls
    logic       model_en;
    int         model_delay;
    logic       model_done;
    logic [7:0] model_res;
    logic       force_en;
    logic       force_done;
    logic [7:0] force_res;
    int         starts_seen = 0;
    int         start_dup   = 0;

    assign bus.done      = force_en ? force_done : model_done;
    assign bus.resultado = force_en ? force_res  : model_res;

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t exceeded, required finish", $time);
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < bound && !ok) begin
            tick();
            cyc++;
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_start"},     32'(bus.start),     32'd0);
        check({pfx, "_valor"},     32'(bus.valor),     32'd0);
        check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({pfx, "_out_data"},  32'(bus.out_data),  32'd0);
        check({pfx, "_out_err"},   32'(bus.out_err),   32'd0);
        check({pfx, "_busy"},      32'(bus.busy),      32'd0);
        check({pfx, "_count"},     32'(bus.count),     32'd0);
        check({pfx, "_in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    // project model: sees start just after the launch edge, then raises done
    // so that it is sampled model_delay edges after that launch edge.
    initial begin
        bit         pending;
        int         cnt;
        logic [7:0] job;
        logic       prev_start;
        pending    = 1'b0;
        cnt        = 0;
        job        = 8'd0;
        prev_start = 1'b0;
        model_done = 1'b0;
        model_res  = 8'd0;
        forever begin
            @(posedge clk0);
            #1;
            model_done = 1'b0;
            if (!rst0) begin
                pending    = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (bus.start === 1'b1) begin
                    starts_seen++;
                    if (prev_start) start_dup++;
                    pending = 1'b1;
                    cnt     = 0;
                    job     = bus.valor;
                end else if (pending && model_en) begin
                    cnt++;
                    if (cnt >= model_delay - 1) begin
                        model_done = 1'b1;
                        model_res  = 8'(job * job);
                        pending    = 1'b0;
                    end
                end
                prev_start = bus.start;
            end
        end
    end

    initial begin
        int         cyc;
        bit         ok;
        int         vbad;
        int         nov;
        logic [7:0] exp2 [5];
        logic [7:0] exp5 [3];
        exp2 = '{8'd1, 8'd4, 8'd9, 8'd16, 8'd25};
        exp5 = '{8'd121, 8'd144, 8'd169};

        rst0          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        model_en      = 1'b1;
        model_delay   = 5;
        force_en      = 1'b0;
        force_done    = 1'b0;
        force_res     = 8'd0;

        // Reset values
        repeat (3) @(posedge clk0);
        #1;
        check_reset("rst");
        rst0 = 1'b1;
        tick();

        // Single job: 3 -> 9, done 5 edges after the launch edge
        push(8'd3);
        check("t1_count_pushed", 32'(bus.count), 32'd1);
        check("t1_start_early",  32'(bus.start), 32'd0);
        tick();
        check("t1_start",  32'(bus.start), 32'd1);
        check("t1_valor",  32'(bus.valor), 32'd3);
        check("t1_busy",   32'(bus.busy),  32'd1);
        check("t1_count0", 32'(bus.count), 32'd0);
        cyc  = 0;
        ok   = 1'b0;
        vbad = 0;
        while (cyc < 40 && !ok) begin
            tick();
            cyc++;
            if (bus.valor !== 8'd3) vbad++;
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
        check("t1_valid_seen",   32'(ok),           32'd1);
        check("t1_latency",      32'(cyc),          32'd5);
        check("t1_valor_stable", 32'(vbad),         32'd0);
        check("t1_data",         32'(bus.out_data), 32'd9);
        check("t1_err",          32'(bus.out_err),  32'd0);
        repeat (3) tick();
        check("t1_hold_valid", 32'(bus.out_valid), 32'd1);
        check("t1_hold_data",  32'(bus.out_data),  32'd9);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t1_consumed",  32'(bus.out_valid), 32'd0);
        check("t1_idle",      32'(bus.busy),      32'd0);
        check("t1_one_start", 32'(starts_seen),   32'd1);

        // Back-to-back fill with done held off; sixth push dropped
        model_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            tick();
            if (i == 2) check("t2_pushpop_count", 32'(bus.count), 32'd1);
        end
        check("t2_count_full", 32'(bus.count),    32'd4);
        check("t2_in_ready",   32'(bus.in_ready), 32'd0);
        bus.in_data = 8'd6;
        tick();
        bus.in_valid = 1'b0;
        check("t2_drop_count", 32'(bus.count), 32'd4);
        check("t2_valor",      32'(bus.valor), 32'd1);
        model_en      = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid(40, cyc, ok);
            check("t2_valid_seen", 32'(ok),           32'd1);
            check("t2_data",       32'(bus.out_data), 32'(exp2[k]));
            check("t2_err",        32'(bus.out_err),  32'd0);
        end
        nov = 0;
        repeat (20) begin
            tick();
            if (bus.out_valid === 1'b1) nov++;
        end
        bus.out_ready = 1'b0;
        check("t2_no_sixth",  32'(nov),         32'd0);
        check("t2_empty",     32'(bus.count),   32'd0);
        check("t2_starts",    32'(starts_seen), 32'd6);

        // Watchdog abort after TIMEOUT WAIT edges, then a normal job
        model_en = 1'b0;
        push(8'd7);
        tick();
        check("t3_start", 32'(bus.start), 32'd1);
        wait_valid(40, cyc, ok);
        check("t3_valid_seen", 32'(ok),           32'd1);
        check("t3_wait_edges", 32'(cyc - 1),      32'(TIMEOUT));
        check("t3_data",       32'(bus.out_data), 32'hFF);
        check("t3_err",        32'(bus.out_err),  32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        push(8'd6);
        model_en = 1'b1;
        wait_valid(40, cyc, ok);
        check("t3_next_seen", 32'(ok),           32'd1);
        check("t3_next_data", 32'(bus.out_data), 32'd36);
        check("t3_next_err",  32'(bus.out_err),  32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // done held high across IDLE and LAUNCH is ignored there
        model_en   = 1'b0;
        force_en   = 1'b1;
        force_done = 1'b1;
        force_res  = 8'h5A;
        repeat (3) tick();
        check("t4_idle_valid", 32'(bus.out_valid), 32'd0);
        check("t4_idle_busy",  32'(bus.busy),      32'd0);
        push(8'd5);
        tick();
        check("t4_start", 32'(bus.start), 32'd1);
        tick();
        check("t4_launch_ignored", 32'(bus.out_valid), 32'd0);
        tick();
        check("t4_wait_capture", 32'(bus.out_valid), 32'd1);
        check("t4_data",         32'(bus.out_data),  32'h5A);
        check("t4_err",          32'(bus.out_err),   32'd0);
        force_en      = 1'b0;
        force_done    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Push and pop on the same edge at count 2
        model_en = 1'b0;
        push(8'd10);
        tick();
        push(8'd11);
        push(8'd12);
        check("t5_count2", 32'(bus.count), 32'd2);
        model_en = 1'b1;
        wait_valid(40, cyc, ok);
        check("t5_first_seen", 32'(ok),           32'd1);
        check("t5_first_data", 32'(bus.out_data), 32'd100);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t5_idle_count", 32'(bus.count), 32'd2);
        check("t5_idle",       32'(bus.busy),  32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd13;
        tick();
        bus.in_valid = 1'b0;
        check("t5_count_same", 32'(bus.count), 32'd2);
        check("t5_start",      32'(bus.start), 32'd1);
        check("t5_valor",      32'(bus.valor), 32'd11);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, cyc, ok);
            check("t5_valid_seen", 32'(ok),           32'd1);
            check("t5_data",       32'(bus.out_data), 32'(exp5[k]));
        end
        tick();
        bus.out_ready = 1'b0;

        // Reset mid-WAIT with two jobs queued
        model_en = 1'b0;
        push(8'd2);
        tick();
        push(8'd3);
        push(8'd4);
        check("t6_count2",  32'(bus.count), 32'd2);
        check("t6_busy",    32'(bus.busy),  32'd1);
        #2;
        rst0 = 1'b0;
        #1;
        check_reset("t6");
        @(posedge clk0);
        @(posedge clk0);
        #3;
        rst0          = 1'b1;
        model_en      = 1'b1;
        bus.out_ready = 1'b1;
        nov = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid === 1'b1) nov++;
        end
        bus.out_ready = 1'b0;
        check("t6_no_result", 32'(nov),         32'd0);
        check("t6_count",     32'(bus.count),   32'd0);
        check("t6_idle",      32'(bus.busy),    32'd0);
        check("all_starts",   32'(starts_seen), 32'd14);
        check("no_start_dup", 32'(start_dup),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
